// File: rtl/c17_wave_sched_pkg.sv
// Shared types and constants for the c17 wave scheduler.
// Optional feature macro used by the design: C17_WAVE_SCHED_SEQ_TAG_EN.
package c17_wave_sched_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DP_IN_W  = 5;
   localparam int DP_OUT_W = 2;
   localparam int TAG_W    = 8;

   // Bits needed to hold any value 0..depth (credit pool and FIFO occupancy).
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/c17_wave_sched_fifo.sv
// Registered (no fall-through) synchronous FIFO used to hold captured results,
// optionally widened to carry the sequence tag next to each result.
module c17_wave_sched_fifo
   import c17_wave_sched_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_push,
   input  logic [WIDTH-1:0]                  i_data,
   input  logic                              i_pop,
   output logic [WIDTH-1:0]                  o_data,
   output logic [credit_width(DEPTH)-1:0]    o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = credit_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;

   // A pop on an empty FIFO is ignored so the caller need not gate it.
   assign w_do_pop = i_pop && (r_count != '0);

   // Storage array; contents need no reset because count qualifies them.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is forced to zero when empty so an idle output is clean.
   assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !w_do_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/c17_wave_sched.sv
// Issue/capture scheduler for the path-balanced c17 datapath. Vectors are
// issued at most one per cycle under credit control, tracked through a
// LATENCY-deep valid shift register and captured into an output FIFO.
// Optional macro: C17_WAVE_SCHED_SEQ_TAG_EN adds an 8-bit issue tag (out_tag).
module c17_wave_sched
   import c17_wave_sched_pkg::*;
#(
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DP_IN_W-1:0]  in_data,
   output logic [DP_IN_W-1:0]  dp_in,
   input  logic [DP_OUT_W-1:0] dp_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DP_OUT_W-1:0] out_data,
   input  logic                flush,
   output logic                flush_done,
   output logic                busy
`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
   ,
   output logic [TAG_W-1:0]    out_tag
`endif
);

   localparam int CRED_W = credit_width(FIFO_DEPTH);
   localparam int SR_W   = LATENCY + 1;
`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
   localparam int FW = DP_OUT_W + TAG_W;
`else
   localparam int FW = DP_OUT_W;
`endif

   state_t              r_state;
   state_t              w_state_next;
   logic [CRED_W-1:0]   r_credits;
   logic [SR_W-1:0]     r_vld_sr;
   logic [DP_IN_W-1:0]  r_dp_in;
   logic                w_issue;
   logic                w_pop;
   logic                w_push;
   logic                w_busy;
   logic [CRED_W-1:0]   w_fifo_count;
   logic [FW-1:0]       w_fifo_wdata;
   logic [FW-1:0]       w_fifo_rdata;

   assign w_issue  = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;
   assign w_push   = r_vld_sr[LATENCY];
   assign w_busy   = (r_vld_sr != '0) || (w_fifo_count != '0);
   assign busy     = w_busy;
   assign out_valid = (w_fifo_count != '0);
   assign dp_in    = r_dp_in;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state plus handshake/done outputs; in_ready is held low during reset.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      flush_done   = 1'b0;
      case (r_state)
         RUN: begin
            in_ready = rst_n && (r_credits != '0);
            if (flush) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!w_busy) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            flush_done   = 1'b1;
            w_state_next = RUN;
         end
         default: w_state_next = RUN;
      endcase
   end

   // Credit pool: one credit per wave between issue and FIFO pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= CRED_W'(FIFO_DEPTH);
      end else if (w_issue && !w_pop) begin
         r_credits <= r_credits - 1'b1;
      end else if (!w_issue && w_pop) begin
         r_credits <= r_credits + 1'b1;
      end
   end

   // Drive the datapath (bubble when nothing issues) and track wave validity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dp_in  <= '0;
         r_vld_sr <= '0;
      end else begin
         r_dp_in  <= w_issue ? in_data : '0;
         r_vld_sr <= (r_vld_sr << 1) | SR_W'(w_issue);
      end
   end

`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
   logic [TAG_W-1:0] r_tag_cnt;
   logic [TAG_W-1:0] r_tag_sr [SR_W];

   // Issue counter; wraps 255 -> 0 by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_cnt <= '0;
      end else if (w_issue) begin
         r_tag_cnt <= r_tag_cnt + 1'b1;
      end
   end

   // Tag pipeline mirrors the valid shift register so the tag meets its result.
   generate
      for (genvar gi = 0; gi < SR_W; gi++) begin : g_tag_sr
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tag_sr[gi] <= '0;
            end else if (gi == 0) begin
               r_tag_sr[gi] <= r_tag_cnt;
            end else begin
               r_tag_sr[gi] <= r_tag_sr[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   assign w_fifo_wdata = {r_tag_sr[LATENCY], dp_out};
   assign out_tag      = w_fifo_rdata[FW-1:DP_OUT_W];
`else
   assign w_fifo_wdata = dp_out;
`endif

   assign out_data = w_fifo_rdata[DP_OUT_W-1:0];

   c17_wave_sched_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_data  (w_fifo_rdata),
      .o_count (w_fifo_count)
   );

   a_credit_invariant: assert property (@(posedge clk) disable iff (!rst_n)
      (int'(r_credits) + $countones(r_vld_sr) + int'(w_fifo_count)) == FIFO_DEPTH);

endmodule

// File: tb/tb_c17_wave_sched.sv
// Self-checking bench for c17_wave_sched: golden c17 behind a LATENCY-stage
// delay line drives dp_out; a queue-based model predicts every output.
// Define C17_WAVE_SCHED_SEQ_TAG_EN to exercise the tag feature.
module tb_c17_wave_sched;

   localparam int LAT   = 3;
   localparam int DEPTH = 8;
   localparam int HALF  = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] in_data = '0;
   logic [4:0] dp_in;
   logic [1:0] dp_out;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] out_data;
   logic       flush = 1'b0;
   logic       flush_done;
   logic       busy;
`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
   logic [7:0] out_tag;
`endif

   int vectors = 0;
   int errors  = 0;
   int checks  = 0;

   always #HALF clk = ~clk;

   c17_wave_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .dp_in      (dp_in),
      .dp_out     (dp_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy)
`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
      ,
      .out_tag    (out_tag)
`endif
   );

   // Golden c17 netlist: {N23, N22}
   function automatic logic [1:0] c17(input logic [4:0] v);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      n1 = v[0]; n2 = v[1]; n3 = v[2]; n6 = v[3]; n7 = v[4];
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n16 & n19), ~(n10 & n16)};
   endfunction

   // Balanced datapath stand-in: LAT clocked stages, then the logic.
   logic [4:0] dl [LAT];
   always @(posedge clk) begin
      dl[0] <= dp_in;
      for (int i = LAT - 1; i > 0; i--) dl[i] <= dl[i-1];
   end
   assign dp_out = c17(dl[LAT-1]);

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [1:0] res;
      int         ready_at;
      int         tag;
   } ent_t;
   ent_t q[$];
   int   now = 0;
   int   tag_ctr = 0;
   bit   m_drain = 0;
   bit   m_done = 0;
   int   exp_dp_in = 0;

   initial forever begin
      bit e_ready, e_valid, pop, iss;
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_data", int'(out_data), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_dp_in", int'(dp_in), 0);
         chk("rst_flush_done", int'(flush_done), 0);
         q.delete();
         now = 0; tag_ctr = 0; m_drain = 0; m_done = 0; exp_dp_in = 0;
      end else begin
         e_ready = !m_drain && !m_done && (q.size() < DEPTH);
         e_valid = (q.size() > 0) && (q[0].ready_at <= now);
         chk("in_ready", int'(in_ready), int'(e_ready));
         chk("out_valid", int'(out_valid), int'(e_valid));
         chk("busy", int'(busy), int'(q.size() != 0));
         chk("flush_done", int'(flush_done), int'(m_done));
         chk("dp_in", int'(dp_in), exp_dp_in);
         if (e_valid) begin
            chk("out_data", int'(out_data), int'(q[0].res));
`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
            chk("out_tag", int'(out_tag), q[0].tag);
`endif
         end
         // advance across the coming edge
         pop = e_valid && out_ready;
         iss = e_ready && in_valid;
         if (m_done) m_done = 0;
         else if (m_drain) begin
            if (q.size() == 0) begin m_drain = 0; m_done = 1; end
         end else if (flush) m_drain = 1;
         if (pop) void'(q.pop_front());
         now++;
         if (iss) begin
            q.push_back('{c17(in_data), now + LAT + 1, tag_ctr});
            tag_ctr = (tag_ctr + 1) % 256;
            vectors++;
            exp_dp_in = int'(in_data);
         end else begin
            exp_dp_in = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] pat [4];
      logic [1:0] res [4];
      int n, acc, pops, dones, stale, k, first_c, last_c, cyc;
      bit seen;
      pat[0] = 5'b10010; pat[1] = 5'b01100; pat[2] = 5'b11110; pat[3] = 5'b00101;
      res[0] = 2'b11;    res[1] = 2'b00;    res[2] = 2'b00;    res[3] = 2'b01;

      repeat (3) step();
      rst_n = 1'b1;

      // single vector: latency and value
      in_valid = 1'b1; in_data = 5'b00101;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      chk("single_latency_edges", n + 1, LAT + 2);
      chk("single_data", int'(out_data), 1);
      out_ready = 1'b1;
      step();

      // stream of 16, results one per cycle in order
      k = 0; acc = 0; first_c = 0; last_c = 0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               in_valid = 1'b1; in_data = pat[i % 4];
               @(negedge clk); if (!in_ready) acc++;
               step();
            end
            in_valid = 1'b0;
         end
         begin
            cyc = 0;
            while (k < 16 && cyc < 200) begin
               @(negedge clk); cyc++;
               if (out_valid && out_ready) begin
                  chk("stream_res", int'(out_data), int'(res[k % 4]));
                  if (k == 0) first_c = cyc;
                  last_c = cyc;
                  k++;
               end
            end
         end
      join
      chk("stream_ready_drops", acc, 0);
      chk("stream_count", k, 16);
      chk("stream_spacing", last_c - first_c, 15);
      step();

      // backpressure: 12 offered, 8 accepted
      out_ready = 1'b0; acc = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_data = 5'($urandom);
         @(negedge clk); if (in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc, DEPTH);
      chk("bp_ready_low", int'(in_ready), 0);
      out_ready = 1'b1; pops = 0; cyc = 0;
      while (pops < DEPTH && cyc < 100) begin
         @(negedge clk); cyc++; if (out_valid) pops++;
         step();
      end
      chk("bp_drained", pops, DEPTH);
      chk("bp_empty", int'(out_valid), 0);
      chk("bp_resume", int'(in_ready), 1);

      // flush with 3 in flight and 2 in the FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 5'($urandom); step();
      end
      in_valid = 1'b0;
      step();
      flush = 1'b1; out_ready = 1'b1;
      pops = 0; dones = 0; seen = 0; cyc = 0;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         if (cyc == 1) chk("flush_ready_low", int'(in_ready), 0);
         if (out_valid) pops++;
         if (flush_done) begin dones++; seen = 1; end
         cyc++;
         step();
         flush = 1'b0;
      end
      chk("flush_pops", pops, 5);
      chk("flush_done_pulses", dones, 1);
      @(negedge clk);
      chk("flush_resume", int'(in_ready), 1);
      step();

      // flush while idle: done two cycles later
      flush = 1'b1; step(); flush = 1'b0;
      n = 1;
      while (!flush_done && n < 20) begin step(); n++; end
      chk("idle_flush_latency", n, 2);
      step(); step();

      // reset with waves in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 5'($urandom); step();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_dp_in", int'(dp_in), 0);
      step();
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); if (out_valid) stale++;
         step();
      end
      chk("midrst_no_stale", stale, 0);
      out_ready = 1'b0; acc = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 5'($urandom);
         @(negedge clk); if (in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      chk("midrst_credits", acc, DEPTH);
      out_ready = 1'b1;

      // randomized traffic with occasional flushes
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = 5'($urandom);
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 80) == 0;
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (busy && cyc < 200) begin step(); cyc++; end
      chk("final_idle", int'(busy), 0);

`ifdef C17_WAVE_SCHED_SEQ_TAG_EN
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      k = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               in_valid = 1'b1; in_data = 5'($urandom); step();
            end
            in_valid = 1'b0;
         end
         begin
            cyc = 0;
            while (k < 300 && cyc < 1000) begin
               @(negedge clk); cyc++;
               if (out_valid && out_ready) begin
                  chk("tag_seq", int'(out_tag), k % 256);
                  k++;
               end
            end
         end
      join
      chk("tag_count", k, 300);
`endif

      step(); step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule
